// File: rtl/dll_train_pkg.sv
// Shared constants and state encoding for the DLL tap trainer.
// Contents: state enum, fixed phase lengths, tap-index/run-length/adj/counter widths.
package dll_train_pkg;

    localparam int unsigned DLL_RST_CYCLES = 4;
    localparam int unsigned SETTLE_CYCLES  = 2;
    localparam int unsigned IDX_W          = 8;
    localparam int unsigned RUN_W          = 9;
    localparam int unsigned ADJ_W          = 8;
    localparam int unsigned CNT_W          = 16;

    typedef enum logic [3:0] {
        IDLE,
        DLL_RST,
        SETTLE,
        WAIT_LOCK,
        SAMPLE,
        NEXT,
        FINAL_SETTLE,
        FINAL_LOCK,
        DONE
    } train_state_e;

endpackage

// File: rtl/dll_tap_trainer_if.sv
// Bundle between the trainer and its environment (host + DLL data path).
// master: host/DLL side, drives start, pattern, sampled data and lock.
// slave : trainer side, drives DLL controls and training status.
interface dll_tap_trainer_if
    import dll_train_pkg::*;
#(
    parameter int unsigned DW = 8
) ();
    logic             io_start;
    logic [DW-1:0]    io_pattern;
    logic [DW-1:0]    io_data_in;
    logic             io_dll_lock;
    logic             io_dll_reset;
    logic [ADJ_W-1:0] io_adj;
    logic [ADJ_W-1:0] io_madj;
    logic             io_busy;
    logic             io_done;
    logic             io_fail;
    logic [ADJ_W-1:0] io_best_adj;

    modport master (
        output io_start, io_pattern, io_data_in, io_dll_lock,
        input  io_dll_reset, io_adj, io_madj, io_busy, io_done, io_fail, io_best_adj
    );

    modport slave (
        input  io_start, io_pattern, io_data_in, io_dll_lock,
        output io_dll_reset, io_adj, io_madj, io_busy, io_done, io_fail, io_best_adj
    );
endinterface

// File: rtl/dll_window_tracker.sv
// Tracks the longest run of consecutive passing taps.
// Ports: clk, rst_n; clear (start a new sweep), valid/pass/index (one tap result);
// best_start/best_len (registered longest window, first one wins on a tie).
module dll_window_tracker
    import dll_train_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             valid,
    input  logic             pass,
    input  logic [IDX_W-1:0] index,
    output logic [RUN_W-1:0] best_start,
    output logic [RUN_W-1:0] best_len
);
    logic [RUN_W-1:0] cur_start_q, cur_start_d;
    logic [RUN_W-1:0] cur_len_q,   cur_len_d;
    logic [RUN_W-1:0] best_start_q, best_start_d;
    logic [RUN_W-1:0] best_len_q,   best_len_d;
    logic [RUN_W-1:0] run_start_c;
    logic [RUN_W-1:0] run_len_c;

    // Extend or break the current run; promote it only when strictly longer.
    always_comb begin
        cur_start_d  = cur_start_q;
        cur_len_d    = cur_len_q;
        best_start_d = best_start_q;
        best_len_d   = best_len_q;
        run_start_c  = (cur_len_q == '0) ? RUN_W'(index) : cur_start_q;
        run_len_c    = cur_len_q + RUN_W'(1);

        if (clear) begin
            cur_start_d  = '0;
            cur_len_d    = '0;
            best_start_d = '0;
            best_len_d   = '0;
        end else if (valid) begin
            if (pass) begin
                cur_start_d = run_start_c;
                cur_len_d   = run_len_c;
                if (run_len_c > best_len_q) begin
                    best_start_d = run_start_c;
                    best_len_d   = run_len_c;
                end
            end else begin
                cur_len_d = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_start_q  <= '0;
            cur_len_q    <= '0;
            best_start_q <= '0;
            best_len_q   <= '0;
        end else begin
            cur_start_q  <= cur_start_d;
            cur_len_q    <= cur_len_d;
            best_start_q <= best_start_d;
            best_len_q   <= best_len_d;
        end
    end

    assign best_start = best_start_q;
    assign best_len   = best_len_q;
endmodule

// File: rtl/dll_tap_trainer.sv
// DLL tap training controller: sweeps io_adj over all taps, checks sampled data
// against a pattern at each tap, then programs the centre of the widest passing window.
// Ports: clock, reset (async, active-low); bus (slave) carrying start/pattern/data/lock
// in and dll_reset/adj/madj/busy/done/fail/best_adj out.
module dll_tap_trainer
    import dll_train_pkg::*;
#(
    parameter int unsigned DW           = 8,
    parameter int unsigned MADJ         = 128,
    parameter int unsigned STEP         = 8,
    parameter int unsigned SAMPLES      = 16,
    parameter int unsigned LOCK_TIMEOUT = 1023
) (
    input  logic               clock,
    input  logic               reset,
    dll_tap_trainer_if.slave   bus
);
    localparam int unsigned NTAPS = MADJ / STEP;

    train_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [ADJ_W-1:0] adj_q, adj_d;
    logic [ADJ_W-1:0] best_adj_q, best_adj_d;
    logic             dll_reset_q, dll_reset_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;
    logic             armed_q;

    logic [DW-1:0]    data_x_c;
    logic             match_c;
    logic             trk_clear_c;
    logic             trk_valid_c;
    logic             fail_now_c;
    logic [RUN_W-1:0] best_start_c;
    logic [RUN_W-1:0] best_len_c;
    logic [RUN_W-1:0] centre_c;

    assign data_x_c = bus.io_data_in ^ bus.io_pattern;
    assign match_c  = (data_x_c == '0);
    assign centre_c = best_start_c + ((best_len_c - RUN_W'(1)) >> 1);

    dll_window_tracker u_tracker (
        .clk        (clock),
        .rst_n      (reset),
        .clear      (trk_clear_c),
        .valid      (trk_valid_c),
        .pass       (match_c),
        .index      (idx_q),
        .best_start (best_start_c),
        .best_len   (best_len_c)
    );

    // Next-state and output-register logic; the tap result is handed to the
    // tracker as SAMPLE exits so the window is final by the time NEXT runs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        adj_d       = adj_q;
        best_adj_d  = best_adj_q;
        dll_reset_d = dll_reset_q;
        busy_d      = busy_q;
        done_d      = done_q;
        fail_d      = fail_q;
        trk_clear_c = 1'b0;
        trk_valid_c = 1'b0;
        fail_now_c  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                // armed_q masks a start sampled on the first edge after reset release.
                if (bus.io_start && armed_q) begin
                    state_d     = DLL_RST;
                    cnt_d       = '0;
                    idx_d       = '0;
                    adj_d       = '0;
                    best_adj_d  = '0;
                    dll_reset_d = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    fail_d      = 1'b0;
                    trk_clear_c = 1'b1;
                end
            end
            DLL_RST: begin
                if (cnt_q == CNT_W'(DLL_RST_CYCLES - 1)) begin
                    dll_reset_d = 1'b0;
                    cnt_d       = '0;
                    state_d     = SETTLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE, FINAL_SETTLE: begin
                // Lock is ignored here: the DLL reports the old lock for a cycle.
                if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = (state_q == SETTLE) ? WAIT_LOCK : FINAL_LOCK;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_LOCK, FINAL_LOCK: begin
                if (bus.io_dll_lock) begin
                    cnt_d = '0;
                    if (state_q == WAIT_LOCK) begin
                        state_d = SAMPLE;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        fail_d  = 1'b0;
                    end
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    fail_now_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                // A single mismatch already fails the tap, so stop early.
                if (!match_c || (cnt_q == CNT_W'(SAMPLES - 1))) begin
                    trk_valid_c = 1'b1;
                    cnt_d       = '0;
                    state_d     = NEXT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            NEXT: begin
                if (idx_q < IDX_W'(NTAPS - 1)) begin
                    idx_d   = idx_q + IDX_W'(1);
                    adj_d   = ADJ_W'((32'(idx_q) + 32'd1) * STEP);
                    state_d = SETTLE;
                end else if (best_len_c == '0) begin
                    fail_now_c = 1'b1;
                end else begin
                    best_adj_d = ADJ_W'(32'(centre_c) * STEP);
                    adj_d      = ADJ_W'(32'(centre_c) * STEP);
                    state_d    = FINAL_SETTLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Failure parks the DLL in reset and reports an empty result.
        if (fail_now_c) begin
            state_d     = IDLE;
            cnt_d       = '0;
            dll_reset_d = 1'b1;
            adj_d       = '0;
            best_adj_d  = '0;
            done_d      = 1'b1;
            fail_d      = 1'b1;
            busy_d      = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            adj_q       <= '0;
            best_adj_q  <= '0;
            dll_reset_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            armed_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            adj_q       <= adj_d;
            best_adj_q  <= best_adj_d;
            dll_reset_q <= dll_reset_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fail_q      <= fail_d;
            armed_q     <= 1'b1;
        end
    end

    assign bus.io_dll_reset = dll_reset_q;
    assign bus.io_adj       = adj_q;
    assign bus.io_madj      = ADJ_W'(MADJ);
    assign bus.io_busy      = busy_q;
    assign bus.io_done      = done_q;
    assign bus.io_fail      = fail_q;
    assign bus.io_best_adj  = best_adj_q;
endmodule

// File: tb/tb_dll_tap_trainer.sv
// Bench for dll_tap_trainer: a small behavioural DLL (lock after a random delay,
// stale lock for one cycle after an adj change) plus a per-tap pass map driving data.
module tb_dll_tap_trainer;
    localparam int unsigned DW           = 8;
    localparam int unsigned MADJ         = 128;
    localparam int unsigned STEP         = 8;
    localparam int unsigned SAMPLES      = 16;
    localparam int unsigned LOCK_TIMEOUT = 1023;
    localparam int unsigned NTAPS        = MADJ / STEP;
    localparam int          RUN_BOUND    = 20000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dll_tap_trainer_if #(.DW(DW)) bus ();

    dll_tap_trainer #(
        .DW(DW), .MADJ(MADJ), .STEP(STEP), .SAMPLES(SAMPLES), .LOCK_TIMEOUT(LOCK_TIMEOUT)
    ) dut (
        .clock (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [15:0]  pass_map;
    bit           no_lock;
    int unsigned  lock_dly;

    // Behavioural DLL: lock after lock_dly stable cycles, drops one cycle late on a change.
    logic [7:0]  adj_prev;
    int unsigned stable;
    logic        lock_q;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q   <= 1'b0;
            stable   <= 0;
            adj_prev <= '0;
        end else begin
            adj_prev <= bus.io_adj;
            if (bus.io_dll_reset) begin
                lock_q <= 1'b0;
                stable <= 0;
            end else if (bus.io_adj != adj_prev) begin
                stable <= 0;
            end else begin
                stable <= stable + 1;
                lock_q <= !no_lock && (stable >= lock_dly);
            end
        end
    end
    assign bus.io_dll_lock = lock_q;

    // Data path: passing taps return the pattern; failing taps are mostly corrupted.
    always @(negedge clk) begin
        int tap;
        tap = int'(bus.io_adj) / int'(STEP);
        if (pass_map[tap[3:0]] || ($urandom_range(0, 2) == 0))
            bus.io_data_in = bus.io_pattern;
        else
            bus.io_data_in = bus.io_pattern ^ 8'($urandom_range(1, 255));
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: widest all-pass window, earliest one for equal widths.
    function automatic void ref_model(input logic [15:0] m, output bit f, output logic [7:0] b);
        f = 1'b1;
        b = '0;
        for (int len = NTAPS; len >= 1 && f; len--) begin
            for (int s = 0; s + len <= NTAPS && f; s++) begin
                bit all_ok = 1'b1;
                for (int k = s; k < s + len; k++) if (!m[k]) all_ok = 1'b0;
                if (all_ok) begin
                    f = 1'b0;
                    b = 8'((s + (len - 1) / 2) * int'(STEP));
                end
            end
        end
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, ".dll_reset"}, bus.io_dll_reset, 1);
        chk({tag, ".adj"},       bus.io_adj, 0);
        chk({tag, ".madj"},      bus.io_madj, MADJ);
        chk({tag, ".busy"},      bus.io_busy, 0);
        chk({tag, ".done"},      bus.io_done, 0);
        chk({tag, ".fail"},      bus.io_fail, 0);
        chk({tag, ".best_adj"},  bus.io_best_adj, 0);
    endtask

    task automatic run_train(input logic [15:0] m, input bit nl, input bit exp_f,
                             input logic [7:0] exp_b, input bit poke, input string tag);
        pass_map       = m;
        no_lock        = nl;
        lock_dly       = $urandom_range(2, 8);
        bus.io_pattern = 8'($urandom);
        @(negedge clk) bus.io_start = 1'b1;
        @(negedge clk) bus.io_start = 1'b0;
        chk({tag, ".busy_rise"}, bus.io_busy, 1);
        chk({tag, ".done_clr"},  bus.io_done, 0);
        if (poke) begin
            repeat (50) @(negedge clk);
            bus.io_start = 1'b1;
            @(negedge clk) bus.io_start = 1'b0;
            chk({tag, ".busy_poke"}, bus.io_busy, 1);
        end
        for (int c = 0; c < RUN_BOUND && !bus.io_done; c++) @(negedge clk);
        chk({tag, ".done"},      bus.io_done, 1);
        chk({tag, ".busy_fall"}, bus.io_busy, 0);
        chk({tag, ".fail"},      bus.io_fail, exp_f);
        chk({tag, ".best_adj"},  bus.io_best_adj, exp_b);
        chk({tag, ".adj"},       bus.io_adj, exp_f ? 8'd0 : exp_b);
        chk({tag, ".dll_reset"}, bus.io_dll_reset, exp_f);
    endtask

    typedef struct {
        logic [15:0] map;
        bit          nolock;
        bit          exp_fail;
        logic [7:0]  exp_best;
    } vec_t;

    initial begin
        vec_t       vecs[5];
        bit         rf;
        logic [7:0] rb;
        logic [15:0] m;

        vecs[0] = '{16'hFFFF, 1'b0, 1'b0, 8'd56};  // all taps pass
        vecs[1] = '{16'h07F0, 1'b0, 1'b0, 8'd56};  // taps 4..10
        vecs[2] = '{16'h1C1C, 1'b0, 1'b0, 8'd24};  // tie, first window wins
        vecs[3] = '{16'hFFFF, 1'b1, 1'b1, 8'd0};   // lock never arrives
        vecs[4] = '{16'h0000, 1'b0, 1'b1, 8'd0};   // pattern never matches

        rst_n          = 1'b0;
        bus.io_start   = 1'b0;
        bus.io_pattern = '0;
        bus.io_data_in = '0;
        pass_map       = '0;
        no_lock        = 1'b0;
        lock_dly       = 4;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 5; i++)
            run_train(vecs[i].map, vecs[i].nolock, vecs[i].exp_fail, vecs[i].exp_best,
                      1'b0, $sformatf("vec%0d", i));

        for (int i = 0; i < 12; i++) begin
            if (i % 2 == 0) begin
                int s;
                int l;
                s = $urandom_range(0, 15);
                l = $urandom_range(1, 16 - s);
                m = 16'($urandom) & 16'($urandom);
                for (int k = s; k < s + l; k++) m[k] = 1'b1;
            end else begin
                m = 16'($urandom);
            end
            ref_model(m, rf, rb);
            run_train(m, 1'b0, rf, rb, 1'b0, $sformatf("rnd%0d_%04h", i, m));
        end

        // Reset while sampling tap 5, then a start coincident with reset release.
        pass_map       = 16'hFFFF;
        no_lock        = 1'b0;
        lock_dly       = 3;
        @(negedge clk) bus.io_start = 1'b1;
        @(negedge clk) bus.io_start = 1'b0;
        for (int c = 0; c < RUN_BOUND && !(bus.io_adj == 8'd40 && lock_q); c++) @(negedge clk);
        chk("mid.reached_tap5", {31'd0, lock_q}, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_vals("mid_rst");
        repeat (2) @(negedge clk);
        check_reset_vals("mid_rst_hold");
        rst_n        = 1'b1;
        bus.io_start = 1'b1;
        @(negedge clk) bus.io_start = 1'b0;
        chk("start_at_release.busy", bus.io_busy, 0);
        @(negedge clk);
        chk("start_at_release.busy2", bus.io_busy, 0);

        run_train(16'hFFFF, 1'b0, 1'b0, 8'd56, 1'b1, "fresh_poke");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
